// File: rtl/ks_pipe_adder_if.sv
// Stream bundle for ks_pipe_adder: operand side and result side.
// The adder takes the slave view; the producer/consumer takes master.
interface ks_pipe_adder_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero,
      input  out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero,
      output out_tag
   );
endinterface

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone add/sub with valid/ready stream and tag sideband.
// One global enable stalls every stage together while the result is held.
module ks_pipe_adder #(
   parameter int WIDTH      = 32,
   parameter int PIPE_EVERY = 2,
   parameter int TAG_W      = 4
) (
   input logic           clk,
   input logic           rst,
   ks_pipe_adder_if.slave io
);
   localparam int LOG2W = $clog2(WIDTH);
   localparam int NSEG  = (LOG2W + PIPE_EVERY - 1) / PIPE_EVERY;

   typedef logic [WIDTH-1:0] vec_t;

   // Register s holds the state entering prefix level s*PIPE_EVERY
   vec_t             g_q  [NSEG];
   vec_t             p_q  [NSEG];
   vec_t             po_q [NSEG];
   logic             v_q  [NSEG];
   logic             am_q [NSEG];
   logic             bm_q [NSEG];
   logic             c0_q [NSEG];
   logic [TAG_W-1:0] t_q  [NSEG];

   logic             out_valid_q;
   vec_t             sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic [TAG_W-1:0] tag_q;

   logic en;
   vec_t b_eff_d;
   vec_t p_d;
   vec_t g_d;
   logic c0_d;

   assign en = !out_valid_q || io.out_ready;

   always_comb begin
      b_eff_d = io.in_sub ? ~io.in_b : io.in_b;
      c0_d    = io.in_sub | io.in_cin;
      p_d     = io.in_a ^ b_eff_d;
      g_d     = io.in_a & b_eff_d;
      g_d[0]  = g_d[0] | (p_d[0] & c0_d);
   end

   vec_t lg_i [LOG2W];
   vec_t lp_i [LOG2W];
   vec_t lg_o [LOG2W];
   vec_t lp_o [LOG2W];

   for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
      if (k % PIPE_EVERY == 0) begin : g_src_reg
         assign lg_i[k] = g_q[k / PIPE_EVERY];
         assign lp_i[k] = p_q[k / PIPE_EVERY];
      end else begin : g_src_chain
         assign lg_i[k] = lg_o[k-1];
         assign lp_i[k] = lp_o[k-1];
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i < (1 << k)) begin : g_pass
            assign lg_o[k][i] = lg_i[k][i];
            assign lp_o[k][i] = lp_i[k][i];
         end else begin : g_op
            assign lg_o[k][i] = lg_i[k][i]
                              | (lp_i[k][i] & lg_i[k][i - (1 << k)]);
            assign lp_o[k][i] = lp_i[k][i] & lp_i[k][i - (1 << k)];
         end
      end
   end

   // Group propagate of the last level has no consumer
   logic unused_p;
   assign unused_p = ^lp_o[LOG2W-1];

   vec_t gf;
   vec_t sum_d;
   logic cout_d;
   logic ovf_d;
   logic zero_d;

   assign gf     = lg_o[LOG2W-1];
   assign sum_d  = po_q[NSEG-1] ^ {gf[WIDTH-2:0], c0_q[NSEG-1]};
   assign cout_d = gf[WIDTH-1];
   assign ovf_d  = (am_q[NSEG-1] == bm_q[NSEG-1])
                && (sum_d[WIDTH-1] != am_q[NSEG-1]);
   assign zero_d = ~|sum_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NSEG; s++) v_q[s] <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         tag_q       <= '0;
      end else if (en) begin
         v_q[0] <= io.in_valid;
         for (int s = 1; s < NSEG; s++) v_q[s] <= v_q[s-1];
         out_valid_q <= v_q[NSEG-1];
         if (v_q[NSEG-1]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            tag_q  <= t_q[NSEG-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         if (io.in_valid) begin
            g_q[0]  <= g_d;
            p_q[0]  <= p_d;
            po_q[0] <= p_d;
            am_q[0] <= io.in_a[WIDTH-1];
            bm_q[0] <= b_eff_d[WIDTH-1];
            c0_q[0] <= c0_d;
            t_q[0]  <= io.in_tag;
         end
         for (int s = 1; s < NSEG; s++) begin
            g_q[s]  <= lg_o[s*PIPE_EVERY-1];
            p_q[s]  <= lp_o[s*PIPE_EVERY-1];
            po_q[s] <= po_q[s-1];
            am_q[s] <= am_q[s-1];
            bm_q[s] <= bm_q[s-1];
            c0_q[s] <= c0_q[s-1];
            t_q[s]  <= t_q[s-1];
         end
      end
   end

   assign io.in_ready  = en;
   assign io.out_valid = out_valid_q;
   assign io.out_sum   = sum_q;
   assign io.out_cout  = cout_q;
   assign io.out_ovf   = ovf_q;
   assign io.out_zero  = zero_q;
   assign io.out_tag   = tag_q;
endmodule

// File: tb/tb_ks_pipe_adder.sv
// Randomised bench for ks_pipe_adder against an arithmetic reference.
// Default config gets directed/stall/reset tests; others a latency sweep.
module tb_ks_pipe_adder;
   localparam int W   = 32;
   localparam int LAT = 4;
   localparam int NCFG = 6;
   localparam int CFG_W [NCFG] = '{4, 4, 16, 16, 64, 64};
   localparam int CFG_P [NCFG] = '{1, 2, 1, 4, 1, 6};

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic rst_g = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ndone  = 0;

   ks_pipe_adder_if #(.WIDTH(W), .TAG_W(4)) m ();
   ks_pipe_adder #(.WIDTH(W), .PIPE_EVERY(2), .TAG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .io  (m)
   );

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] s;
      logic [2:0]  f;
      logic [3:0]  t;
      int          cy;
      bit          lc;
   } exp_t;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub,
                                  input logic [3:0] t);
      exp_t e;
      logic [32:0] f;
      logic [32:0] x;
      f = sub ? ({1'b0, a} - {1'b0, b})
              : ({1'b0, a} + {1'b0, b} + {32'b0, cin});
      x = sub ? ({a[31], a} - {b[31], b})
              : ({a[31], a} + {b[31], b} + {32'b0, cin});
      e.s  = f[31:0];
      e.f  = {sub ? ~f[32] : f[32], x[32] ^ x[31], ~|f[31:0]};
      e.t  = t;
      e.cy = 0;
      e.lc = 1'b0;
      return e;
   endfunction

   exp_t        exq [$];
   int          cyc    = 0;
   int          ntake  = 0;
   bit          held   = 1'b0;
   bit          acc    = 1'b0;
   logic [38:0] held_v = '0;
   logic [31:0] last_s = '0;

   task automatic step(input bit v, input logic [31:0] a,
                       input logic [31:0] b, input logic cin,
                       input logic sub, input logic [3:0] tg,
                       input bit ordy, input bit lc);
      exp_t e;
      logic [38:0] cur;
      @(negedge clk);
      m.in_valid  = v;
      m.in_a      = a;
      m.in_b      = b;
      m.in_cin    = cin;
      m.in_sub    = sub;
      m.in_tag    = tg;
      m.out_ready = ordy;
      #1;
      cyc++;
      cur = {m.out_cout, m.out_ovf, m.out_zero, m.out_tag, m.out_sum};
      chk("in_ready", 128'(m.in_ready), 128'(!m.out_valid || m.out_ready));
      if (held) begin
         chk("held valid", 128'(m.out_valid), 128'(1'b1));
         chk("held data", 128'(cur), 128'(held_v));
      end
      held   = m.out_valid && !m.out_ready;
      held_v = cur;
      if (m.out_valid && m.out_ready) begin
         ntake++;
         last_s = m.out_sum;
         if (exq.size() == 0) begin
            chk("spurious out_valid", 128'(m.out_valid), 128'(1'b0));
         end else begin
            e = exq.pop_front();
            chk("sum", 128'(m.out_sum), 128'(e.s));
            chk("cout/ovf/zero",
                128'({m.out_cout, m.out_ovf, m.out_zero}), 128'(e.f));
            chk("tag", 128'(m.out_tag), 128'(e.t));
            if (e.lc) chk("latency", 128'(cyc - e.cy), 128'(LAT));
         end
      end
      acc = v && m.in_ready;
      if (acc) begin
         e    = model(a, b, cin, sub, tg);
         e.cy = cyc;
         e.lc = lc;
         exq.push_back(e);
      end
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, ordy, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exq.size() != 0; i++) idle(1'b1);
      chk("drain leftover", 128'(exq.size()), 128'(0));
   endtask

   initial begin
      int n0;
      int idx;
      logic [31:0] oa [5];
      logic [31:0] ob [5];
      logic        os [5];
      m.in_valid  = 1'b0;
      m.in_a      = '0;
      m.in_b      = '0;
      m.in_cin    = 1'b0;
      m.in_sub    = 1'b0;
      m.in_tag    = '0;
      m.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset out_valid", 128'(m.out_valid), 128'(1'b0));
      chk("reset outputs", 128'({m.out_cout, m.out_ovf, m.out_zero,
                                 m.out_tag, m.out_sum}), 128'(0));
      chk("reset in_ready", 128'(m.in_ready), 128'(1'b1));
      rst   = 1'b0;
      rst_g = 1'b0;

      step(1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1);
      step(1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1);
      step(1'b1, 32'h80000000, 32'h1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
      step(1'b1, 32'h12345678, 32'h12345678, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1);
      step(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1);
      drain();

      n0 = ntake;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), i[3:0], 1'b1, 1'b1);
         chk("stream accept", 128'(acc), 128'(1'b1));
      end
      drain();
      chk("stream count", 128'(ntake - n0), 128'(100));
      idle(1'b1);
      idle(1'b1);
      chk("idle keeps sum", 128'(m.out_sum), 128'(last_s));
      chk("idle valid", 128'(m.out_valid), 128'(1'b0));

      for (int i = 0; i < 5; i++) begin
         oa[i] = $urandom;
         ob[i] = $urandom;
         os[i] = 1'($urandom_range(0, 1));
      end
      idx = 0;
      n0  = ntake;
      for (int c = 0; c < 6; c++) begin
         step(idx < 5, oa[idx % 5], ob[idx % 5], 1'b1, os[idx % 5],
              4'(idx + 8), 1'b0, 1'b0);
         if (acc) idx++;
      end
      chk("stall accepted", 128'(idx), 128'(4));
      chk("stall in_ready", 128'(m.in_ready), 128'(1'b0));
      for (int c = 0; c < 40 && (idx < 5 || exq.size() != 0); c++) begin
         step(idx < 5, oa[idx % 5], ob[idx % 5], 1'b1, os[idx % 5],
              4'(idx + 8), 1'b1, 1'b0);
         if (acc) idx++;
      end
      chk("stall issued", 128'(idx), 128'(5));
      chk("stall results", 128'(ntake - n0), 128'(5));
      chk("stall leftover", 128'(exq.size()), 128'(0));

      for (int c = 0; c < 5; c++)
         step(c < 3, $urandom, $urandom, 1'b0, 1'b0, 4'(c), 1'b0, 1'b0);
      @(negedge clk);
      rst        = 1'b1;
      m.in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("mid reset out_valid", 128'(m.out_valid), 128'(1'b0));
      chk("mid reset outputs", 128'({m.out_cout, m.out_ovf, m.out_zero,
                                     m.out_tag, m.out_sum}), 128'(0));
      chk("mid reset in_ready", 128'(m.in_ready), 128'(1'b1));
      rst  = 1'b0;
      held = 1'b0;
      exq.delete();
      for (int c = 0; c < 6; c++) idle(1'b1);
      step(1'b1, 32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0, 4'hA, 1'b1, 1'b1);
      drain();

      wait (ndone == NCFG);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_sw
      localparam int GW   = CFG_W[gi];
      localparam int GP   = CFG_P[gi];
      localparam int GL   = ($clog2(GW) + GP - 1) / GP + 1;
      localparam int NOPS = (GW == 4) ? 768 : 64;

      ks_pipe_adder_if #(.WIDTH(GW), .TAG_W(4)) s ();
      ks_pipe_adder #(.WIDTH(GW), .PIPE_EVERY(GP), .TAG_W(4)) u (
         .clk (clk),
         .rst (rst_g),
         .io  (s)
      );

      initial begin : run
         logic [GW-1:0] qs [$];
         logic [6:0]    qf [$];
         int            qc [$];
         logic [GW-1:0] a;
         logic [GW-1:0] b;
         logic [GW:0]   f;
         logic [GW:0]   x;
         logic          cin;
         logic          sub;
         int            gc;
         gc          = 0;
         s.in_valid  = 1'b0;
         s.in_a      = '0;
         s.in_b      = '0;
         s.in_cin    = 1'b0;
         s.in_sub    = 1'b0;
         s.in_tag    = '0;
         s.out_ready = 1'b1;
         wait (!rst_g);
         for (int n = 0; n < NOPS + GL + 4; n++) begin
            @(negedge clk);
            if (GW == 4) begin
               a   = GW'(n[3:0]);
               b   = GW'(n[7:4]);
               cin = n[8];
               sub = n[9];
            end else begin
               a   = GW'({$urandom, $urandom});
               b   = GW'({$urandom, $urandom});
               cin = 1'($urandom_range(0, 1));
               sub = 1'($urandom_range(0, 1));
               if (n % 8 == 0) b = a;
            end
            s.in_valid = (n < NOPS) && (GW == 4 || $urandom_range(0, 3) != 0);
            s.in_a     = a;
            s.in_b     = b;
            s.in_cin   = cin;
            s.in_sub   = sub;
            s.in_tag   = n[3:0];
            #1;
            gc++;
            if (s.out_valid) begin
               if (qs.size() == 0) begin
                  chk("sweep spurious", 128'(s.out_valid), 128'(1'b0));
               end else begin
                  chk($sformatf("w%0d/p%0d sum", GW, GP),
                      128'(s.out_sum), 128'(qs.pop_front()));
                  chk($sformatf("w%0d/p%0d flags+tag", GW, GP),
                      128'({s.out_cout, s.out_ovf, s.out_zero, s.out_tag}),
                      128'(qf.pop_front()));
                  chk($sformatf("w%0d/p%0d latency", GW, GP),
                      128'(gc - qc.pop_front()), 128'(GL));
               end
            end
            if (s.in_valid && s.in_ready) begin
               f = sub ? ({1'b0, a} - {1'b0, b})
                       : ({1'b0, a} + {1'b0, b} + {{GW{1'b0}}, cin});
               x = sub ? ({a[GW-1], a} - {b[GW-1], b})
                       : ({a[GW-1], a} + {b[GW-1], b} + {{GW{1'b0}}, cin});
               qs.push_back(f[GW-1:0]);
               qf.push_back({sub ? ~f[GW] : f[GW], x[GW] ^ x[GW-1],
                             ~|f[GW-1:0], n[3:0]});
               qc.push_back(gc);
            end
         end
         chk($sformatf("w%0d/p%0d leftover", GW, GP),
             128'(qs.size()), 128'(0));
         ndone++;
      end
   end
endmodule
